seq_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the 4-bit combinational a/b→o lab block.
- Processes CHUNK bits per clock, LSB first, so a wide operand pair completes in WIDTH/CHUNK cycles.
- Uses a start/busy/done handshake and registered outputs.
- Adds subtract mode, carry/borrow out and signed overflow.
- Sits between a stimulus/controller and any consumer that samples o on done.

---
 rtl/seq_addsub_pkg.sv | 7 +
 rtl/addsub_chunk.sv | 12 +
 rtl/seq_addsub.sv | 80 ++++++++
 tb/tb_seq_addsub.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared FSM encoding and counter sizing for seq_addsub
package seq_addsub_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder slice with carry in/out
module addsub_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(ci);
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, CHUNK bits per clock LSB first
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_bits(N);
  state_t           st;
  logic [WIDTH-1:0] opa, opb, res, res_n;
  logic [CW-1:0]    cnt;
  logic             carry, sa, sb, co, last;
  logic [CHUNK-1:0] s;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x (opa[CHUNK-1:0]),
    .y (opb[CHUNK-1:0]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  assign res_n = (res >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
  assign last  = cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      o     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
    end else if (st == ST_RUN) begin
      opa   <= opa >> CHUNK;
      opb   <= opb >> CHUNK;
      res   <= res_n;
      carry <= co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        o    <= res_n;
        cout <= co;
        ovf  <= (sa == sb) && (res_n[WIDTH-1] != sa);
        st   <= ST_DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        opa   <= a;
        opb   <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
        sa    <= a[WIDTH-1];
        sb    <= b[WIDTH-1] ^ sub;
        st    <= ST_RUN;
        busy  <= 1'b1;
      end else begin
        st <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: randomized self-checking bench for three seq_addsub configurations
module tb_seq_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] st = '0, sbm = '0;
  logic [7:0] av [3];
  logic [7:0] bv [3];
  logic [2:0] bz, dn, co, ov;
  logic [3:0] o0;
  logic [7:0] o1, o2;
  int tot = 0, pass = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(4), .CHUNK(1)) d0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sbm[0]),
    .a(av[0][3:0]), .b(bv[0][3:0]), .busy(bz[0]), .done(dn[0]), .o(o0), .cout(co[0]), .ovf(ov[0]));
  seq_addsub #(.WIDTH(8), .CHUNK(2)) d1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sbm[1]),
    .a(av[1]), .b(bv[1]), .busy(bz[1]), .done(dn[1]), .o(o1), .cout(co[1]), .ovf(ov[1]));
  seq_addsub #(.WIDTH(8), .CHUNK(8)) d2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sbm[2]),
    .a(av[2]), .b(bv[2]), .busy(bz[2]), .done(dn[2]), .o(o2), .cout(co[2]), .ovf(ov[2]));

  function automatic int wid(input int s);
    return (s == 0) ? 4 : 8;
  endfunction

  function automatic int nchunks(input int s);
    return (s == 0) ? 4 : (s == 1) ? 4 : 1;
  endfunction

  function automatic logic [7:0] get_o(input int s);
    return (s == 0) ? {4'h0, o0} : (s == 1) ? o1 : o2;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input int s, input logic [7:0] x, input logic [7:0] y, input logic m,
                                output logic [7:0] eo, output logic ec, output logic ev);
    int w, ux, uy, sx, sy, r, sr;
    w  = wid(s);
    ux = int'(x) & ((1 << w) - 1);
    uy = int'(y) & ((1 << w) - 1);
    sx = (ux >= (1 << (w - 1))) ? ux - (1 << w) : ux;
    sy = (uy >= (1 << (w - 1))) ? uy - (1 << w) : uy;
    r  = m ? ux - uy : ux + uy;
    sr = m ? sx - sy : sx + sy;
    eo = 8'(r & ((1 << w) - 1));
    ec = m ? (ux >= uy) : (r >= (1 << w));
    ev = (sr < -(1 << (w - 1))) || (sr >= (1 << (w - 1)));
  endfunction

  task automatic do_op(input int s, input logic [7:0] x, input logic [7:0] y, input logic m, input string nm);
    logic [7:0] eo;
    logic ec, ev;
    int cyc;
    model(s, x, y, m, eo, ec, ev);
    @(negedge clk);
    st[s] = 1'b1; sbm[s] = m; av[s] = x; bv[s] = y;
    @(posedge clk); #1;
    st[s] = 1'b0; av[s] = 8'($urandom); bv[s] = 8'($urandom); sbm[s] = 1'($urandom);
    tot++; if (bz[s] !== 1'b1) $display("FAIL %s busy_rise got %b exp 1", nm, bz[s]); else pass++;
    cyc = 0;
    while (dn[s] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    tot++; if (cyc !== nchunks(s)) $display("FAIL %s latency got %0d exp %0d", nm, cyc, nchunks(s)); else pass++;
    tot++; if (get_o(s) !== eo) $display("FAIL %s o got %h exp %h", nm, get_o(s), eo); else pass++;
    tot++; if (co[s] !== ec) $display("FAIL %s cout got %b exp %b", nm, co[s], ec); else pass++;
    tot++; if (ov[s] !== ev) $display("FAIL %s ovf got %b exp %b", nm, ov[s], ev); else pass++;
    tot++; if (bz[s] !== 1'b0) $display("FAIL %s busy_in_done got %b exp 0", nm, bz[s]); else pass++;
    @(posedge clk); #1;
    tot++; if (dn[s] !== 1'b0) $display("FAIL %s done_width got %b exp 0", nm, dn[s]); else pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      tot++;
      if ({bz[s], dn[s], co[s], ov[s], get_o(s)} !== 12'h0)
        $display("FAIL reset inst%0d busy/done/cout/ovf/o got %b%b%b%b/%h exp 0", s, bz[s], dn[s], co[s], ov[s], get_o(s));
      else pass++;
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_plan_add();
    do_op(0, 8'd0, 8'd3, 1'b0, "add_0_3");
    do_op(0, 8'd3, 8'd3, 1'b0, "add_3_3");
    do_op(0, 8'd15, 8'd3, 1'b0, "add_15_3");
    do_op(0, 8'd15, 8'd15, 1'b0, "add_15_15");
    do_op(0, 8'd1, 8'd1, 1'b0, "add_1_1");
    do_op(0, 8'd7, 8'd1, 1'b0, "add_ovf_7_1");
  endtask

  task automatic test_plan_sub();
    do_op(0, 8'd3, 8'd3, 1'b1, "sub_3_3");
    do_op(0, 8'd1, 8'd2, 1'b1, "sub_1_2");
    do_op(0, 8'd8, 8'd1, 1'b1, "sub_ovf_8_1");
    do_op(0, 8'd0, 8'd8, 1'b1, "sub_0_8");
  endtask

  task automatic test_wide();
    do_op(1, 8'hF3, 8'h1F, 1'b0, "c2_f3_1f");
    do_op(2, 8'h80, 8'h80, 1'b0, "c8_80_80");
    do_op(1, 8'h7F, 8'hFF, 1'b1, "c2_sub_ovf");
    do_op(2, 8'h00, 8'h01, 1'b1, "c8_sub_borrow");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      for (int s = 0; s < 3; s++)
        do_op(s, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d_inst%0d", i, s));
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    st[0] = 1'b1; sbm[0] = 1'b0; av[0] = 8'd3; bv[0] = 8'd5;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b1; sbm[0] = 1'b1; av[0] = 8'd9; bv[0] = 8'd2;
    @(negedge clk);
    st[0] = 1'b0;
    cyc = 2;
    while (dn[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    tot++; if (cyc !== 4) $display("FAIL ignore latency got %0d exp 4", cyc); else pass++;
    tot++; if (o0 !== 4'd8) $display("FAIL ignore o got %h exp 8", o0); else pass++;
    @(posedge clk); #1;
    tot++; if (bz[0] !== 1'b0) $display("FAIL ignore restarted busy got %b exp 0", bz[0]); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] eo;
    logic ec, ev;
    int cyc;
    model(0, 8'd5, 8'd6, 1'b1, eo, ec, ev);
    @(negedge clk);
    st[0] = 1'b1; sbm[0] = 1'b0; av[0] = 8'd2; bv[0] = 8'd3;
    @(posedge clk); #1;
    av[0] = 8'd5; bv[0] = 8'd6; sbm[0] = 1'b1;
    cyc = 0;
    while (dn[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    tot++; if (o0 !== 4'd5) $display("FAIL b2b first o got %h exp 5", o0); else pass++;
    @(posedge clk); #1;
    st[0] = 1'b0;
    tot++; if (bz[0] !== 1'b1) $display("FAIL b2b no_idle busy got %b exp 1", bz[0]); else pass++;
    tot++; if (o0 !== 4'd5) $display("FAIL b2b hold o got %h exp 5", o0); else pass++;
    cyc = 0;
    while (dn[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    tot++; if (cyc !== 4) $display("FAIL b2b second latency got %0d exp 4", cyc); else pass++;
    tot++; if ({o0, co[0], ov[0]} !== {eo[3:0], ec, ev})
      $display("FAIL b2b second o/cout/ovf got %h/%b/%b exp %h/%b/%b", o0, co[0], ov[0], eo[3:0], ec, ev);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_op(0, 8'd3, 8'd4, 1'b0, "pre_reset");
    @(negedge clk);
    st[0] = 1'b1; sbm[0] = 1'b0; av[0] = 8'd1; bv[0] = 8'd1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tot++; if (bz[0] !== 1'b0) $display("FAIL rst_mid busy got %b exp 0", bz[0]); else pass++;
    tot++; if (o0 !== 4'd0) $display("FAIL rst_mid o got %h exp 0", o0); else pass++;
    #4 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (dn[0] === 1'b1 || bz[0] === 1'b1) seen++; end
    tot++; if (seen !== 0) $display("FAIL rst_mid stray done/busy got %0d exp 0", seen); else pass++;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin av[s] = '0; bv[s] = '0; end
    test_reset();
    test_plan_add();
    test_plan_sub();
    test_wide();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
